data_memory: RTL and testbench

Byte-addressable data memory for the single-cycle (monocycle) RISC-V datapath, sitting behind the ALU result (address) and the rs2 operand (write data). It supports byte, half-word and word stores and loads. Loads can be signed or unsigned. Writes are synchronous; reads are combinational, so a load completes within the same cycle, as the single-cycle core requires. The block is little-endian and accepts unaligned accesses.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_load_ext.sv | 22 ++
 rtl/data_memory.sv | 62 ++++++
 tb/tb_data_memory.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data memory: access-type encodings and default size.
package dm_pkg;

    localparam int DM_DEPTH = 1024;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    // Number of bytes a store of this access type writes; zero for load-only or illegal codes.
    function automatic logic [2:0] store_len(input logic [2:0] ctrl);
        logic [2:0] len;
        case (ctrl)
            DM_B:    len = 3'd1;
            DM_H:    len = 3'd2;
            DM_W:    len = 3'd4;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load formatter: selects byte/half/word from the four fetched little-endian bytes and extends it.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] fetched,
    input  logic [2:0]  ctrl,
    output logic [31:0] data
);

    always_comb begin
        data = 32'h0;
        case (ctrl)
            DM_B:    data = {{24{fetched[7]}}, fetched[7:0]};
            DM_H:    data = {{16{fetched[15]}}, fetched[15:0]};
            DM_W:    data = fetched;
            DM_BU:   data = {24'h0, fetched[7:0]};
            DM_HU:   data = {16'h0, fetched[15:0]};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory: synchronous stores, combinational loads,
// unaligned accesses wrap modulo DEPTH.
module data_memory
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic [2:0]  DMCtrl,
    input  logic        DMWr,
    output logic [31:0] DataRd
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] lane_idx [4];
    logic [7:0]    lane_wdata [4];
    logic [3:0]    lane_we;
    logic [2:0]    wr_len;
    logic [31:0]   fetched;
    logic          unused_addr_hi;

    // Only the low AW address bits select a byte; the rest alias.
    assign unused_addr_hi = ^Address[31:AW];

    assign wr_len = DMWr ? store_len(DMCtrl) : 3'd0;

    // Lane k carries byte k of the access; the AW-bit add wraps past the top of memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_idx[gi]        = Address[AW-1:0] + AW'(gi);
            assign lane_wdata[gi]      = DataWr[8*gi +: 8];
            assign lane_we[gi]         = (wr_len > 3'(gi));
            assign fetched[8*gi +: 8]  = mem[lane_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lane_we[k]) begin
                    mem[lane_idx[k]] <= lane_wdata[k];
                end
            end
        end
    end

    dm_load_ext u_load_ext (
        .fetched (fetched),
        .ctrl    (DMCtrl),
        .data    (DataRd)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: byte-array model checked every cycle plus literal expectations.
module tb_data_memory;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic [2:0]  DMCtrl;
    logic        DMWr;
    logic [31:0] DataRd;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [7:0] model_mem [DEPTH];

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Address (Address),
        .DataWr  (DataWr),
        .DMCtrl  (DMCtrl),
        .DMWr    (DMWr),
        .DataRd  (DataRd)
    );

    always #5 clk = ~clk;

    // Model: reset clears everything at once, a store writes its bytes at the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        end else if (DMWr) begin
            int n;
            int base;
            case (DMCtrl)
                3'b000:  n = 1;
                3'b001:  n = 2;
                3'b010:  n = 4;
                default: n = 0;
            endcase
            base = int'(Address % DEPTH);
            for (int k = 0; k < n; k++) model_mem[(base + k) % DEPTH] = DataWr[8*k +: 8];
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] ctrl);
        longint v = 0;
        int n;
        int base;
        bit signed_ld;
        case (ctrl)
            3'b000:  begin n = 1; signed_ld = 1; end
            3'b001:  begin n = 2; signed_ld = 1; end
            3'b010:  begin n = 4; signed_ld = 0; end
            3'b100:  begin n = 1; signed_ld = 0; end
            3'b101:  begin n = 2; signed_ld = 0; end
            default: return 32'h0;
        endcase
        base = int'(addr % DEPTH);
        for (int k = 0; k < n; k++) v += longint'(model_mem[(base + k) % DEPTH]) << (8 * k);
        if (signed_ld && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp;
            exp = model_read(Address, DMCtrl);
            checks++;
            if (DataRd !== exp) begin
                failures++;
                $display("FAIL model t=%0t addr=%h ctrl=%b got=%h exp=%h", $time, Address, DMCtrl, DataRd, exp);
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
        DMWr    = we;
        DMCtrl  = ctrl;
        Address = addr;
        DataWr  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        checks++;
        if (DataRd !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, DataRd, exp);
        end else begin
            $display("ok   %s: %h", name, DataRd);
        end
    endtask

    task automatic store(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, ctrl, addr, data);
        $display("st   ctrl=%b addr=%h data=%h", ctrl, addr, data);
        step();
    endtask

    task automatic load(input string name, input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b0, ctrl, addr, 32'hDEADBEEF);
        #2;
        lit(name, exp);
        step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        load("reset_lb10", 3'b000, 32'd10, 32'h00000000);

        store(3'b000, 32'd0, 32'hF00000F8);
        store(3'b001, 32'd1, 32'h0000FFFE);
        store(3'b010, 32'd3, 32'h80000001);
        load("lb0",  3'b000, 32'd0, 32'hFFFFFFF8);
        load("lh1",  3'b001, 32'd1, 32'hFFFFFFFE);
        load("lw3",  3'b010, 32'd3, 32'h80000001);
        load("lhu1", 3'b101, 32'd1, 32'h0000FFFE);
        load("lbu0", 3'b100, 32'd0, 32'h000000F8);

        store(3'b010, DEPTH - 2, 32'hAABBCCDD);
        load("wrap_lw",       3'b010, DEPTH - 2,         32'hAABBCCDD);
        load("wrap_lbu0",     3'b100, 32'd0,             32'h000000BB);
        load("wrap_alias_lw", 3'b010, 2 * DEPTH - 2,     32'hAABBCCDD);
        load("wrap_hi_lhu",   3'b101, 32'hFFFF_FFFF,     32'h0000BBCC);

        store(3'b010, 32'd8, 32'hCAFEF00D);
        drive(1'b1, 3'b010, 32'd8, 32'h12345678);
        #2;
        lit("collide_before", 32'hCAFEF00D);
        step();
        lit("collide_after", 32'h12345678);

        store(3'b111, 32'd8, 32'hFFFFFFFF);
        store(3'b100, 32'd8, 32'hFFFFFFFF);
        store(3'b011, 32'd8, 32'hFFFFFFFF);
        load("illegal_st_lw8", 3'b010, 32'd8,  32'h12345678);
        load("ld_011",         3'b011, 32'd8,  32'h00000000);
        load("ld_110",         3'b110, 32'd8,  32'h00000000);
        load("lb8",            3'b000, 32'd8,  32'h00000078);
        load("lh10",           3'b001, 32'd10, 32'h00001234);

        drive(1'b0, 3'b010, 32'd8, 32'h0);
        #1;
        lit("pre_reset_lw8", 32'h12345678);
        #1 rst_n = 1'b0;
        #1;
        lit("async_reset_lw8", 32'h00000000);
        drive(1'b0, 3'b010, 32'd3, 32'h0);
        #1;
        lit("async_reset_lw3", 32'h00000000);
        drive(1'b1, 3'b010, 32'd16, 32'h55555555);
        step();
        rst_n = 1'b1;
        load("store_in_reset_lost", 3'b010, 32'd16, 32'h00000000);
        store(3'b010, 32'd16, 32'h55555555);
        load("first_store_after_reset", 3'b010, 32'd16, 32'h55555555);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
